muldiv_unit: RTL and testbench

- Iterative multiply/divide execute unit for the RISC-V M extension; sits beside the single-cycle ALU in the EX stage.
- Decodes `funct3` into the eight M-extension operations, computes one result bit per cycle, and returns the result over a valid/ready handshake.
- Hazard logic holds the pipeline while `busy` is high.
- Width is parametrised; divide-by-zero and signed overflow take a fast path that bypasses iteration.

---
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 tb/tb_muldiv_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: radix-2 shift-add multiply,
// restoring divide, one result bit per cycle, with a fast path for divide-by-zero and overflow.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// CALC  | one multiplier / quotient bit per cycle
// FIX   | sign correction and field select
// DONE  | result written, out_valid pulse
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            out_valid,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   mcand_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;

  logic            a_signed, b_signed, sign_a, sign_b, neg_in;
  logic            b_zero, ovf, fast;
  logic [XLEN-1:0] mag_a, mag_b, fast_val;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'b010:  a_signed = 1'b1;
      default: ;
    endcase
    sign_a   = a_signed & op_a[XLEN-1];
    sign_b   = b_signed & op_b[XLEN-1];
    mag_a    = sign_a ? (~op_a + 1'b1) : op_a;
    mag_b    = sign_b ? (~op_b + 1'b1) : op_b;
    // REM takes the dividend's sign; every other op takes the product/quotient sign
    neg_in   = (funct3 == 3'b110) ? sign_a : (sign_a ^ sign_b);
    b_zero   = (op_b == '0);
    ovf      = !funct3[0] && (op_a == MOST_NEG) && (op_b == '1);
    fast     = funct3[2] && (b_zero || ovf);
    fast_val = funct3[1] ? (b_zero ? op_a : '0) : (b_zero ? '1 : MOST_NEG);
  end

  logic [XLEN-1:0]   acc_hi, acc_lo, add_term;
  logic [XLEN:0]     mul_sum, rem_shift;
  logic [XLEN+1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] acc_mul, acc_div, prod_fix;
  logic [XLEN-1:0]   fix_val;

  always_comb begin
    acc_hi    = acc_q[2*XLEN-1:XLEN];
    acc_lo    = acc_q[XLEN-1:0];
    add_term  = acc_lo[0] ? mcand_q : '0;
    mul_sum   = {1'b0, acc_hi} + {1'b0, add_term};
    acc_mul   = {mul_sum, acc_lo[XLEN-1:1]};
    rem_shift = {acc_hi, acc_lo[XLEN-1]};
    div_diff  = {1'b0, rem_shift} - {2'b00, mcand_q};
    div_ge    = ~div_diff[XLEN+1];
    acc_div   = {(div_ge ? div_diff[XLEN-1:0] : rem_shift[XLEN-1:0]),
                 acc_lo[XLEN-2:0], div_ge};
    // the whole product is negated so the high half carries the borrow correctly
    prod_fix  = neg_q ? (~acc_q + 1'b1) : acc_q;
    if (!op_q[2])
      fix_val = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else if (!op_q[1])
      fix_val = neg_q ? (~acc_lo + 1'b1) : acc_lo;
    else
      fix_val = neg_q ? (~acc_hi + 1'b1) : acc_hi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      neg_q     <= 1'b0;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (in_valid) begin
            op_q  <= funct3;
            neg_q <= neg_in;
            cnt_q <= CNT_W'(XLEN);
            if (funct3[2]) begin
              acc_q   <= {{XLEN{1'b0}}, mag_a};
              mcand_q <= mag_b;
            end else begin
              acc_q   <= {{XLEN{1'b0}}, mag_b};
              mcand_q <= mag_a;
            end
            if (fast) begin
              result    <= fast_val;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= CALC;
            end
          end
          CALC: begin
            acc_q <= op_q[2] ? acc_div : acc_mul;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state <= FIX;
          end
          FIX: begin
            result    <= fix_val;
            out_valid <= 1'b1;
            state     <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy     = (state != IDLE);
  assign in_ready = (state == IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit at XLEN=32 and XLEN=8: directed corner cases, handshake,
// flush and reset behaviour, plus randomized ops against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        iv32, iv8;
  logic [2:0]  f3;
  logic [31:0] opa, opb;
  logic        flush;
  logic        rdy32, busy32, ov32;
  logic [31:0] res32;
  logic        rdy8, busy8, ov8;
  logic [7:0]  res8;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] last32;

  muldiv_unit #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(rdy32), .funct3(f3),
    .op_a(opa), .op_b(opb), .flush(flush), .busy(busy32), .out_valid(ov32),
    .result(res32)
  );

  muldiv_unit #(.XLEN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(rdy8), .funct3(f3),
    .op_a(opa[7:0]), .op_b(opb[7:0]), .flush(flush), .busy(busy8), .out_valid(ov8),
    .result(res8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic rdy_of(int w);  return (w == 32) ? rdy32  : rdy8;  endfunction
  function automatic logic busy_of(int w); return (w == 32) ? busy32 : busy8; endfunction
  function automatic logic ov_of(int w);   return (w == 32) ? ov32   : ov8;   endfunction
  function automatic logic [31:0] res_of(int w);
    return (w == 32) ? res32 : {24'h0, res8};
  endfunction

  function automatic logic [31:0] mask_of(int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 1);
  endfunction

  // Reference: plain integer arithmetic on sign/zero-extended operands
  function automatic logic [31:0] model(int w, logic [2:0] f, logic [31:0] a_in, logic [31:0] b_in);
    logic [31:0] m, a, b;
    longint sa, sb, ua, ub, r;
    logic signed [127:0] ea, eb, p;
    m  = mask_of(w);
    a  = a_in & m;
    b  = b_in & m;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[w-1] ? ua - (longint'(1) << w) : ua;
    sb = b[w-1] ? ub - (longint'(1) << w) : ub;
    case (f)
      3'b000, 3'b001: begin ea = sa; eb = sb; end
      3'b010:         begin ea = sa; eb = ub; end
      default:        begin ea = ua; eb = ub; end
    endcase
    p = ea * eb;
    case (f)
      3'b000:  return p[31:0] & m;
      3'b001, 3'b010, 3'b011: begin p = p >>> w; return p[31:0] & m; end
      default: begin
        if (b == 0) return f[1] ? a : m;
        case (f)
          3'b100:  r = sa / sb;
          3'b101:  r = ua / ub;
          3'b110:  r = sa % sb;
          default: r = ua % ub;
        endcase
        return r[31:0] & m;
      end
    endcase
  endfunction

  function automatic int exp_lat(int w, logic [2:0] f, logic [31:0] a_in, logic [31:0] b_in);
    logic [31:0] m, a, b, mn;
    m  = mask_of(w);
    a  = a_in & m;
    b  = b_in & m;
    mn = 32'h1 << (w - 1);
    if (f[2] && (b == 0)) return 1;
    if ((f == 3'b100 || f == 3'b110) && a == mn && b == m) return 1;
    return w + 2;
  endfunction

  // Issue one op, wait for completion, check result, latency, busy length and pulse width.
  task automatic do_op(input int w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat_exp,
                       input bit hold, input string tag);
    int t, lat, bcnt;
    bit seen;
    f3 = f; opa = a; opb = b;
    if (w == 32) iv32 = 1'b1; else iv8 = 1'b1;
    t = 0;
    while (!rdy_of(w) && t < 200) begin @(posedge clk); #1; t++; end
    check({tag, "_ready"}, rdy_of(w), 1'b1);
    @(posedge clk); #1;
    if (!hold) begin
      if (w == 32) iv32 = 1'b0; else iv8 = 1'b0;
    end
    seen = 0; lat = 0; bcnt = 0;
    for (int k = 1; k <= 100; k++) begin
      if (!hold) begin f3 = 3'($urandom); opa = $urandom; opb = $urandom; end
      if (busy_of(w)) bcnt++;
      if (ov_of(w)) begin seen = 1; lat = k; break; end
      @(posedge clk); #1;
    end
    if (!seen) check({tag, "_timeout"}, 0, 1);
    check({tag, "_result"}, res_of(w), exp);
    check({tag, "_latency"}, lat, lat_exp);
    check({tag, "_busy_cycles"}, bcnt, lat_exp);
    @(posedge clk); #1;
    check({tag, "_pulse"}, {ov_of(w), rdy_of(w)}, 2'b01);
    if (w == 32) last32 = exp;
  endtask

  initial begin
    int cnt;
    logic [2:0]  rf;
    logic [31:0] ra, rb, m;
    rst_n = 1'b0; iv32 = 1'b0; iv8 = 1'b0; f3 = '0; opa = '0; opb = '0; flush = 1'b0;
    last32 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset32", {rdy32, busy32, ov32, res32}, {3'b100, 32'h0});
    check("reset8",  {rdy8, busy8, ov8, res8},     {3'b100, 8'h0});
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(32, 3'b000, 32'd7, -32'sd3, 32'hFFFF_FFEB, 34, 0, "mul_7x-3");
    do_op(32, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0, "mulh_min");
    do_op(32, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0, "mulhu_max");
    do_op(32, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0, "mulhsu");
    do_op(32, 3'b100, -32'sd7, 32'd2, 32'hFFFF_FFFD, 34, 0, "div_-7/2");
    do_op(32, 3'b110, -32'sd7, 32'd2, 32'hFFFF_FFFF, 34, 0, "rem_-7/2");
    do_op(32, 3'b101, 32'd100, 32'd7, 32'd14, 34, 0, "divu_100/7");
    do_op(32, 3'b111, 32'd100, 32'd7, 32'd2, 34, 0, "remu_100/7");
    do_op(32, 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, "fast_divu0");
    do_op(32, 3'b110, 32'd5, 32'd0, 32'd5, 1, 0, "fast_rem0");
    do_op(32, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "fast_divovf");
    do_op(32, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, "fast_removf");

    // in_valid held high across three ops
    do_op(32, 3'b000, 32'd12, 32'd11, 32'd132, 34, 1, "hold0");
    do_op(32, 3'b101, 32'd1000, 32'd10, 32'd100, 34, 1, "hold1");
    do_op(32, 3'b111, 32'd9, 32'd0, 32'd9, 1, 1, "hold2");
    iv32 = 1'b0;

    // flush in CALC cycle 10 of a MUL
    f3 = 3'b000; opa = 32'd3; opb = 32'd5; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle", {rdy32, busy32}, 2'b10);
    cnt = 0;
    repeat (40) begin if (ov32) cnt++; @(posedge clk); #1; end
    check("flush_no_valid", cnt, 0);
    check("flush_result_kept", res32, last32);

    // flush together with a request in IDLE
    f3 = 3'b101; opa = 32'd5; opb = 32'd0; iv32 = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0; flush = 1'b0;
    check("flush_no_accept", {rdy32, busy32, ov32}, 3'b100);

    // asynchronous reset mid-DIV
    f3 = 3'b100; opa = 32'd1234; opb = 32'd7; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("async_reset", {rdy32, busy32, ov32, res32}, {3'b100, 32'h0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin if (ov32) cnt++; @(posedge clk); #1; end
    check("reset_discard", cnt, 0);
    last32 = '0;
    do_op(32, 3'b101, 32'd9, 32'd3, 32'd3, 34, 0, "divu_9/3");

    // XLEN = 8
    do_op(8, 3'b011, 32'hFF, 32'hFF, 32'hFE, 10, 0, "x8_mulhu");
    do_op(8, 3'b100, 32'h80, 32'hFF, 32'h80, 1, 0, "x8_divovf");
    do_op(8, 3'b110, 32'hF9, 32'h02, 32'hFF, 10, 0, "x8_rem");

    // randomized ops at both widths
    for (int i = 0; i < 60; i++) begin
      int w;
      w  = (i % 2 == 0) ? 32 : 8;
      m  = mask_of(w);
      rf = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0: ra = 32'h1 << (w - 1);
        1: ra = m;
        default: ra = $urandom & m;
      endcase
      case ($urandom_range(0, 7))
        0: rb = 0;
        1: rb = m;
        2: rb = $urandom_range(1, 9);
        default: rb = $urandom & m;
      endcase
      do_op(w, rf, ra, rb, model(w, rf, ra, rb), exp_lat(w, rf, ra, rb), 0,
            $sformatf("rand%0d_f%0d", i, rf));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
